proc_control: RTL

//  Control unit of the simple processor; sits directly upstream of the 3-to-8 register-select decoders.

---
 rtl/proc_pkg.sv | 31 +++
 rtl/proc_control_dec3to8.sv | 13 +
 rtl/proc_control.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared types and encodings for the processor control unit.
package proc_pkg;

  localparam int DIN_W     = 9;
  localparam int REG_SEL_W = 3;
  localparam int NREG      = 2 ** REG_SEL_W;

  typedef enum logic [1:0] {T0, T1, T2, T3} tstep_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  function automatic logic [1:0] alu_code(input logic [2:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_control_dec3to8.sv
// 3-to-8 one-hot register-select decoder with enable; all-zero when disabled.
module dec3to8 (
  input  logic [2:0] W,
  input  logic       En,
  output logic [7:0] Y
);

  always_comb begin
    Y = 8'h00;
    if (En) Y[W] = 1'b1;
  end

endmodule

// File: rtl/proc_control.sv
// Control unit: captures an instruction in T0 and sequences it through T1..T3.
// Build option PROC_CTRL_LOGIC_OPS_EN enables the and/or opcodes (otherwise 1xx are NOPs).
//
// state | meaning
// T0    | idle / instruction fetch, IRin high, Run captures DIN into IR
// T1    | mv/mvi complete, ALU op reads dest into A, NOP completes
// T2    | ALU op reads src, loads G
// T3    | ALU op writes G back to dest
module proc_control
  import proc_pkg::*;
#(
  parameter int DIN_W     = proc_pkg::DIN_W,
  parameter int REG_SEL_W = proc_pkg::REG_SEL_W
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Run,
  input  logic [DIN_W-1:0]          DIN,
  output logic                      IRin,
  output logic [2**REG_SEL_W-1:0]   Rin,
  output logic [2**REG_SEL_W-1:0]   Rout,
  output logic                      DINout,
  output logic                      Ain,
  output logic                      Gin,
  output logic                      Gout,
  output logic                      AddSub,
  output logic [1:0]                AluOp,
  output logic                      Done
);

  tstep_t               tstep, tstep_nxt;
  logic [DIN_W-1:0]     ir;
  logic [2:0]           opcode;
  logic [REG_SEL_W-1:0] reg_x, reg_y;
  logic                 is_alu;
  logic                 rin_en, rout_en, rout_sel_x;

  assign opcode = ir[DIN_W-1 -: 3];
  assign reg_x  = ir[2*REG_SEL_W-1 -: REG_SEL_W];
  assign reg_y  = ir[REG_SEL_W-1:0];

`ifdef PROC_CTRL_LOGIC_OPS_EN
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                  (opcode == OP_AND) || (opcode == OP_OR);
`else
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tstep <= T0;
      ir    <= '0;
    end else begin
      tstep <= tstep_nxt;
      if (tstep == T0 && Run) ir <= DIN;
    end
  end

  always_comb begin
    tstep_nxt  = tstep;
    IRin       = 1'b0;
    DINout     = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    Gout       = 1'b0;
    AddSub     = 1'b0;
    AluOp      = ALU_ADD;
    Done       = 1'b0;
    rin_en     = 1'b0;
    rout_en    = 1'b0;
    rout_sel_x = 1'b0;

    case (tstep)
      T0: begin
        IRin = 1'b1;
        if (Run) tstep_nxt = T1;
      end
      T1: begin
        tstep_nxt = T0;
        if (opcode == OP_MV) begin
          rout_en = 1'b1;
          rin_en  = 1'b1;
          Done    = 1'b1;
        end else if (opcode == OP_MVI) begin
          DINout = 1'b1;
          rin_en = 1'b1;
          Done   = 1'b1;
        end else if (is_alu) begin
          rout_en    = 1'b1;
          rout_sel_x = 1'b1;
          Ain        = 1'b1;
          tstep_nxt  = T2;
        end else begin
          Done = 1'b1;
        end
      end
      T2: begin
        tstep_nxt = is_alu ? T3 : T0;
        if (is_alu) begin
          rout_en = 1'b1;
          Gin     = 1'b1;
          AddSub  = (opcode == OP_SUB);
          AluOp   = alu_code(opcode);
        end
      end
      T3: begin
        tstep_nxt = T0;
        Gout      = 1'b1;
        rin_en    = 1'b1;
        Done      = 1'b1;
      end
      default: tstep_nxt = T0;
    endcase

    // Reset forces every strobe low, including IRin.
    if (Reset) begin
      IRin    = 1'b0;
      DINout  = 1'b0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      Gout    = 1'b0;
      AddSub  = 1'b0;
      AluOp   = ALU_ADD;
      Done    = 1'b0;
      rin_en  = 1'b0;
      rout_en = 1'b0;
    end
  end

  dec3to8 decX (
    .W  (reg_x),
    .En (rin_en),
    .Y  (Rin)
  );

  dec3to8 decY (
    .W  (rout_sel_x ? reg_x : reg_y),
    .En (rout_en),
    .Y  (Rout)
  );

endmodule
